l2_mem_responder: RTL and testbench

Memory-side responder for the L2 arbiter's outbound memory request stream. It accepts `l2_mem_request_t` requests and write data, services them from an internal word-addressed on-chip RAM, and returns read data as `l2_mem_return_data_t` tagged with the originating port id and sub_id. It sits where external memory would otherwise attach, and serves as the on-chip memory and simulation endpoint for the L2 subsystem.

---
 rtl/l2_mem_responder_if.sv | 46 ++++
 rtl/l2_mem_responder.sv | 139 +++++++++++++
 tb/tb_l2_mem_responder.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_mem_responder_if.sv
// Request/return types shared with the L2 arbiter, plus the memory-side bus
// that carries requests, write data and tagged read data.
package l2_config_and_types;
  localparam int L2_ID_W     = 3;
  localparam int L2_SUB_ID_W = 2;
  localparam int L2_ADDR_W   = 30;

  typedef struct packed {
    logic [L2_ADDR_W-1:0]   addr;
    logic [3:0]             be;
    logic [L2_ID_W-1:0]     id;
    logic                   rnw;
    logic                   is_amo;
    logic [4:0]             amo_type_or_burst_size;
  } l2_mem_request_t;

  typedef struct packed {
    logic [L2_ID_W-L2_SUB_ID_W-1:0] id;
    logic [L2_SUB_ID_W-1:0]         sub_id;
    logic [31:0]                    data;
  } l2_mem_return_data_t;
endpackage

interface l2_mem_if;
  import l2_config_and_types::*;

  l2_mem_request_t     mem_request;
  logic                request_valid;
  logic                request_ack;
  logic [31:0]         wr_data;
  logic                wr_data_valid;
  logic                wr_data_ack;
  l2_mem_return_data_t rd_data;
  logic                rd_data_valid;
  logic                rd_data_ready;

  modport master (
    output mem_request, request_valid, wr_data, wr_data_valid, rd_data_ready,
    input  request_ack, wr_data_ack, rd_data, rd_data_valid
  );

  modport slave (
    input  mem_request, request_valid, wr_data, wr_data_valid, rd_data_ready,
    output request_ack, wr_data_ack, rd_data, rd_data_valid
  );
endinterface

// File: rtl/l2_mem_responder.sv
// On-chip RAM endpoint for the L2 memory request stream: services read/write
// bursts in order and returns tagged read words through a 2-entry output buffer.
module l2_mem_responder
  import l2_config_and_types::*;
#(
  parameter int MEM_DEPTH_WORDS = 4096
) (
  input  logic    clk,
  input  logic    rst,
  l2_mem_if.slave mem_bus
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  localparam int TW = L2_ID_W - L2_SUB_ID_W;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [3:0]             be_q, be_d;
  logic [TW-1:0]          tag_id_q, tag_id_d;
  logic [L2_SUB_ID_W-1:0] tag_sub_q, tag_sub_d;
  logic [4:0]             cnt_q, cnt_d;

  logic [31:0]            mem [MEM_DEPTH_WORDS];

  l2_mem_return_data_t    buf_q [2];
  logic                   buf_wr_ptr_q, buf_rd_ptr_q;
  logic [1:0]             buf_cnt_q;

  logic                   req_ack, wr_ack, rd_issue, wr_en, buf_pop, credit_ok, rd_valid;

  // Read data is captured straight into the output buffer at the issue edge,
  // so buffer occupancy alone is the credit count.
  assign credit_ok = (buf_cnt_q < 2'd2);
  assign rd_valid  = (buf_cnt_q != 2'd0);
  assign buf_pop   = rd_valid && mem_bus.rd_data_ready;

  if (AW < L2_ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_bus.mem_request.addr[L2_ADDR_W-1:AW];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    tag_id_d  = tag_id_q;
    tag_sub_d = tag_sub_q;
    cnt_d     = cnt_q;
    req_ack   = 1'b0;
    wr_ack    = 1'b0;
    rd_issue  = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Acceptance is held off while reset is asserted so the ack stays low.
        if (rst && mem_bus.request_valid) begin
          req_ack   = 1'b1;
          addr_d    = mem_bus.mem_request.addr[AW-1:0];
          be_d      = mem_bus.mem_request.be;
          tag_id_d  = mem_bus.mem_request.id[L2_ID_W-1:L2_SUB_ID_W];
          tag_sub_d = mem_bus.mem_request.id[L2_SUB_ID_W-1:0];
          cnt_d     = mem_bus.mem_request.is_amo ? 5'd0
                                                 : mem_bus.mem_request.amo_type_or_burst_size;
          state_d   = mem_bus.mem_request.rnw ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        if (credit_ok) begin
          rd_issue = 1'b1;
          addr_d   = addr_q + AW'(1);
          cnt_d    = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (mem_bus.wr_data_valid) begin
          wr_ack = 1'b1;
          wr_en  = 1'b1;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      be_q         <= '0;
      tag_id_q     <= '0;
      tag_sub_q    <= '0;
      cnt_q        <= '0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      buf_wr_ptr_q <= 1'b0;
      buf_rd_ptr_q <= 1'b0;
      buf_cnt_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      tag_id_q  <= tag_id_d;
      tag_sub_q <= tag_sub_d;
      cnt_q     <= cnt_d;
      if (rd_issue) begin
        buf_q[buf_wr_ptr_q] <= '{id: tag_id_q, sub_id: tag_sub_q, data: mem[addr_q]};
        buf_wr_ptr_q        <= ~buf_wr_ptr_q;
      end
      if (buf_pop) buf_rd_ptr_q <= ~buf_rd_ptr_q;
      case ({rd_issue, buf_pop})
        2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
        2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
        default: buf_cnt_q <= buf_cnt_q;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; only control state is cleared, so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[addr_q][8*b +: 8] <= mem_bus.wr_data[8*b +: 8];
      end
    end
  end

  assign mem_bus.request_ack   = req_ack;
  assign mem_bus.wr_data_ack   = wr_ack;
  assign mem_bus.rd_data_valid = rd_valid;
  assign mem_bus.rd_data       = rd_valid ? buf_q[buf_rd_ptr_q] : '0;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: reset, reads, backpressure, byte enables,
// wrap-around, AMO, back-to-back acceptance and reset mid-burst.
module tb_l2_mem_responder;
  import l2_config_and_types::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0]         wbuf [32];
  l2_mem_return_data_t got_q [$];

  l2_mem_if bus ();

  l2_mem_responder #(.MEM_DEPTH_WORDS(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input logic [29:0] addr, input logic [3:0] be, input logic [2:0] id,
                            input logic rnw, input logic amo, input logic [4:0] bs);
    l2_mem_request_t r;
    bit ok;
    r = '0;
    r.addr = addr; r.be = be; r.id = id; r.rnw = rnw; r.is_amo = amo;
    r.amo_type_or_burst_size = bs;
    bus.mem_request   = r;
    bus.request_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.request_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept addr=%h: request_ack never seen, required 1", addr);
    end
    step();
    bus.request_valid = 1'b0;
    bus.mem_request   = '0;
  endtask

  task automatic write_burst(input logic [29:0] addr, input logic [3:0] be, input int len);
    accept_req(addr, be, 3'b000, 1'b0, 1'b0, 5'(len - 1));
    for (int i = 0; i < len; i++) begin
      bus.wr_data       = wbuf[i];
      bus.wr_data_valid = 1'b1;
      @(negedge clk);
      total++;
      if (bus.wr_data_ack !== 1'b1) begin
        bad++;
        $display("FAIL write_ack addr=%h word=%0d got=%b exp=1", addr, i, bus.wr_data_ack);
      end
      step();
    end
    bus.wr_data_valid = 1'b0;
    bus.wr_data       = '0;
  endtask

  task automatic read_burst(input logic [29:0] addr, input logic [2:0] id, input int n, input logic amo);
    accept_req(addr, 4'hF, id, 1'b1, amo, amo ? 5'h1F : 5'(n - 1));
    got_q.delete();
    bus.rd_data_ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < n; c++) begin
      @(negedge clk);
      if (bus.rd_data_valid === 1'b1) got_q.push_back(bus.rd_data);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.rd_data_valid !== 1'b0) begin
        bad++;
        $display("FAIL read_extra addr=%h got valid=%b data=%h exp valid=0", addr, bus.rd_data_valid, bus.rd_data.data);
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) step();
    @(negedge clk);
    total++;
    if ({bus.request_ack, bus.wr_data_ack, bus.rd_data_valid} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000", {bus.request_ack, bus.wr_data_ack, bus.rd_data_valid});
    end
    total++;
    if (bus.rd_data !== '0) begin
      bad++;
      $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data);
    end
    rst = 1'b1;
    step();
    bus.wr_data       = 32'h1234_5678;
    bus.wr_data_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (bus.wr_data_ack !== 1'b0) begin
        bad++;
        $display("FAIL idle_wr_ack cycle=%0d got=%b exp=0", i, bus.wr_data_ack);
      end
      step();
    end
    bus.wr_data_valid = 1'b0;
    bus.wr_data       = '0;
  endtask

  task automatic test_single_read();
    wbuf[0] = 32'hDEAD_BEEF;
    write_burst(30'h10, 4'hF, 1);
    accept_req(30'h10, 4'hF, 3'b110, 1'b1, 1'b0, 5'd0);
    bus.rd_data_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_t1_valid got=%b exp=0", bus.rd_data_valid);
    end
    step();
    @(negedge clk);
    total++;
    if ({bus.rd_data_valid, bus.rd_data} !== {1'b1, 1'b1, 2'b10, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL single_t2 got valid=%b id=%h sub=%h data=%h exp 1/1/2/deadbeef",
               bus.rd_data_valid, bus.rd_data.id, bus.rd_data.sub_id, bus.rd_data.data);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_t3_valid got=%b exp=0", bus.rd_data_valid);
    end
    step();
  endtask

  task automatic test_burst_backpressure();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int got;
    logic prev_valid, prev_ready;
    l2_mem_return_data_t prev_data;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i);
    write_burst(30'h20, 4'hF, 4);
    accept_req(30'h20, 4'hF, 3'b101, 1'b1, 1'b0, 5'd3);
    bus.rd_data_ready = 1'b0;
    step();
    got = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 20; c++) begin
      bus.rd_data_ready = (c < 7) ? pat[c] : 1'b1;
      @(negedge clk);
      if (c == 0) begin
        total++;
        if (bus.rd_data_valid !== 1'b1) begin
          bad++;
          $display("FAIL burst_latency got valid=%b exp=1", bus.rd_data_valid);
        end
      end
      if (prev_valid && !prev_ready) begin
        total++;
        if ({bus.rd_data_valid, bus.rd_data} !== {1'b1, prev_data}) begin
          bad++;
          $display("FAIL burst_stable cycle=%0d got valid=%b data=%h exp 1/%h",
                   c, bus.rd_data_valid, bus.rd_data, prev_data);
        end
      end
      if (bus.rd_data_valid === 1'b1) begin
        total++;
        if (got >= 4 || bus.rd_data !== {1'b1, 2'b01, 32'(got)}) begin
          bad++;
          $display("FAIL burst_word cycle=%0d got=%h exp index %0d of 4 (data=%0d id=1 sub=1)",
                   c, bus.rd_data, got, got);
        end
        if (bus.rd_data_ready) got++;
      end
      prev_valid = bus.rd_data_valid;
      prev_ready = bus.rd_data_ready;
      prev_data  = bus.rd_data;
      step();
    end
    total++;
    if (got != 4) begin
      bad++;
      $display("FAIL burst_count got=%0d exp=4", got);
    end
  endtask

  task automatic test_byte_enable();
    wbuf[0] = 32'h1122_3344;
    write_burst(30'h30, 4'hF, 1);
    wbuf[0] = 32'hAABB_CCDD;
    write_burst(30'h30, 4'b0101, 1);
    read_burst(30'h30, 3'b000, 1, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0].data !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL byte_enable got words=%0d first=%h exp 1 word 11bb33dd",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'h0);
    end
  endtask

  task automatic test_wrap();
    wbuf[0] = 32'h1;
    wbuf[1] = 32'h2;
    write_burst(30'(DEPTH - 1), 4'hF, 2);
    read_burst(30'(DEPTH - 1), 3'b000, 2, 1'b0);
    total++;
    if (got_q.size() != 2 || got_q[0].data !== 32'h1 || got_q[1].data !== 32'h2) begin
      bad++;
      $display("FAIL wrap_burst got words=%0d exp 2 words 1,2", got_q.size());
    end
    read_burst(30'h0, 3'b000, 1, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0].data !== 32'h2) begin
      bad++;
      $display("FAIL wrap_word0 got words=%0d data=%h exp 1 word 2",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'h0);
    end
    read_burst(30'(DEPTH), 3'b000, 1, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0].data !== 32'h2) begin
      bad++;
      $display("FAIL upper_addr_ignored got words=%0d data=%h exp 1 word 2",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'h0);
    end
  endtask

  task automatic test_amo();
    int acks;
    read_burst(30'h21, 3'b011, 1, 1'b1);
    total++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 2'b11, 32'h1}) begin
      bad++;
      $display("FAIL amo_read got words=%0d first=%h exp 1 word id0 sub3 data1",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
    end
    accept_req(30'h40, 4'hF, 3'b000, 1'b0, 1'b1, 5'h1F);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data       = 32'h55 + 32'(i) * 32'h11;
      bus.wr_data_valid = 1'b1;
      @(negedge clk);
      if (bus.wr_data_ack === 1'b1) acks++;
      step();
    end
    bus.wr_data_valid = 1'b0;
    total++;
    if (acks != 1) begin
      bad++;
      $display("FAIL amo_write_acks got=%0d exp=1", acks);
    end
    read_burst(30'h40, 3'b000, 1, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0].data !== 32'h55) begin
      bad++;
      $display("FAIL amo_write_data got words=%0d data=%h exp 1 word 55",
               got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    int ack_c [$];
    int word_c [$];
    logic [31:0] word_d [$];
    int phase;
    bit saw_ack;
    l2_mem_request_t r;
    r = '0;
    r.addr = 30'h20; r.id = 3'b010; r.rnw = 1'b1; r.amo_type_or_burst_size = 5'd1; r.be = 4'hF;
    bus.mem_request   = r;
    bus.request_valid = 1'b1;
    bus.rd_data_ready = 1'b1;
    phase = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      saw_ack = (bus.request_ack === 1'b1);
      if (saw_ack) ack_c.push_back(c);
      if (bus.rd_data_valid === 1'b1) begin
        word_c.push_back(c);
        word_d.push_back(bus.rd_data.data);
      end
      step();
      if (saw_ack && phase == 0) begin
        r.addr = 30'h30; r.id = 3'b111; r.amo_type_or_burst_size = 5'd0;
        bus.mem_request = r;
        phase = 1;
      end else if (saw_ack && phase == 1) begin
        bus.request_valid = 1'b0;
        bus.mem_request   = '0;
        phase = 2;
      end
    end
    bus.request_valid = 1'b0;
    total++;
    if (ack_c.size() != 2 || ack_c[0] != 0 || ack_c[1] != 3) begin
      bad++;
      $display("FAIL b2b_ack_cycles got count=%0d first=%0d second=%0d exp 2 acks at 0,3", ack_c.size(),
               (ack_c.size() > 0) ? ack_c[0] : -1, (ack_c.size() > 1) ? ack_c[1] : -1);
    end
    total++;
    if (word_c.size() != 3 || word_c[0] != 2 || word_c[1] != 3 || word_c[2] != 5) begin
      bad++;
      $display("FAIL b2b_word_cycles got count=%0d exp 3 words at 2,3,5", word_c.size());
    end
    total++;
    if (word_d.size() != 3 || word_d[0] !== 32'h0 || word_d[1] !== 32'h1 || word_d[2] !== 32'h11BB_33DD) begin
      bad++;
      $display("FAIL b2b_word_data got count=%0d exp 0,1,11bb33dd", word_d.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int got;
    bit hit;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + 32'(i);
    write_burst(30'h50, 4'hF, 8);
    accept_req(30'h50, 4'hF, 3'b001, 1'b1, 1'b0, 5'd7);
    bus.rd_data_ready = 1'b1;
    got = 0;
    hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rd_data_valid === 1'b1) begin
        if (got == 2) begin
          total++;
          if (bus.rd_data.data !== 32'hA2) begin
            bad++;
            $display("FAIL rst_burst_word3 got=%h exp=a2", bus.rd_data.data);
          end
          #1 rst = 1'b0;
          #1;
          total++;
          if ({bus.request_ack, bus.wr_data_ack, bus.rd_data_valid, bus.rd_data} !== '0) begin
            bad++;
            $display("FAIL rst_outputs got ack=%b wack=%b valid=%b data=%h exp all 0",
                     bus.request_ack, bus.wr_data_ack, bus.rd_data_valid, bus.rd_data);
          end
          hit = 1'b1;
          break;
        end
        got++;
      end
      step();
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL rst_third_word got words=%0d exp third word seen", got);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (bus.rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_stale_valid got=%b exp=0", bus.rd_data_valid);
    end
    step();
    read_burst(30'h57, 3'b100, 1, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 2'b00, 32'hA7}) begin
      bad++;
      $display("FAIL rst_after_read got words=%0d first=%h exp 1 word id1 sub0 data a7",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
    end
  endtask

  initial begin
    rst               = 1'b0;
    bus.mem_request   = '0;
    bus.request_valid = 1'b0;
    bus.wr_data       = '0;
    bus.wr_data_valid = 1'b0;
    bus.rd_data_ready = 1'b0;
    test_reset();
    test_single_read();
    test_burst_backpressure();
    test_byte_enable();
    test_wrap();
    test_amo();
    test_back_to_back();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
